// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the datapath.
// The master side is the controller: it reads IR fields and the zero flag and drives every datapath control.
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             PCWr;
    logic             IRWr;
    logic             RegWr;
    logic             MemWr;
    logic             RegDst;
    logic             MemtoReg;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             ExtOp;
    logic [1:0]       PCSrc;
    logic [2:0]       ALUop;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op, funct, zero,
        output PCWr, IRWr, RegWr, MemWr, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
               ExtOp, PCSrc, ALUop, state, instr_cnt
    );

    modport slave (
        output op, funct, zero,
        input  PCWr, IRWr, RegWr, MemWr, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
               ExtOp, PCSrc, ALUop, state, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset main control: controls are decoded combinationally from the state register (BR's PCWr also
// follows zero) and each instruction takes 3-5 cycles. There is no backpressure; a retired-instruction counter is kept.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_DCD   = 4'd1,
        S_EXE   = 4'd2,
        S_EXE_I = 4'd3,
        S_ALUWB = 4'd4,
        S_MA    = 4'd5,
        S_MR    = 4'd6,
        S_MW    = 4'd7,
        S_MWB   = 4'd8,
        S_BR    = 4'd9,
        S_JMP   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    always_comb begin
        state_d      = S_FETCH;
        retire       = 1'b0;
        bus.PCWr     = 1'b0;
        bus.IRWr     = 1'b0;
        bus.RegWr    = 1'b0;
        bus.MemWr    = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ExtOp    = 1'b1;
        bus.PCSrc    = 2'b00;
        bus.ALUop    = 3'b001;

        case (state_q)
            S_FETCH: begin
                bus.IRWr    = 1'b1;
                bus.PCWr    = 1'b1;
                bus.ALUSrcB = 2'b01;
                state_d     = S_DCD;
            end
            // Speculatively compute the branch target into ALUOut while decoding.
            S_DCD: begin
                bus.ALUSrcB = 2'b11;
                case (bus.op)
                    OP_RTYPE: begin
                        if (bus.funct == FN_ADDU || bus.funct == FN_SUBU ||
                            bus.funct == FN_OR   || bus.funct == FN_SLT) begin
                            state_d = S_EXE;
                        end
                    end
                    OP_ORI:        state_d = S_EXE_I;
                    OP_LW, OP_SW:  state_d = S_MA;
                    OP_BEQ:        state_d = S_BR;
                    OP_J:          state_d = S_JMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_EXE: begin
                bus.ALUSrcA = 1'b1;
                case (bus.funct)
                    FN_SUBU: bus.ALUop = 3'b101;
                    FN_OR:   bus.ALUop = 3'b010;
                    FN_SLT:  bus.ALUop = 3'b111;
                    default: bus.ALUop = 3'b001;
                endcase
                state_d = S_ALUWB;
            end
            S_EXE_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b0;
                bus.ALUop   = 3'b010;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegWr  = 1'b1;
                bus.RegDst = (bus.op == OP_RTYPE);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MA: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                state_d     = (bus.op == OP_LW) ? S_MR : S_MW;
            end
            S_MR: begin
                state_d = S_MWB;
            end
            S_MWB: begin
                bus.RegWr    = 1'b1;
                bus.MemtoReg = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MW: begin
                bus.MemWr = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = 3'b101;
                bus.PCSrc   = 2'b01;
                bus.PCWr    = bus.zero;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JMP: begin
                bus.PCWr  = 1'b1;
                bus.PCSrc = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset must not let a half-finished instruction touch PC, IR, registers or memory.
        if (rst) begin
            bus.PCWr  = 1'b0;
            bus.IRWr  = 1'b0;
            bus.RegWr = 1'b0;
            bus.MemWr = 1'b0;
        end

        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed plus randomized check of mc_ctrl against an instruction-level model of state paths, controls and the
// retired count; a second instance with a 4-bit counter is run in lockstep to exercise wraparound.
module tb_mc_ctrl;
    localparam int C_R = 0, C_ORI = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_J = 5, C_BAD = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_r, funct_r;
    logic       zero_r;
    int         total = 0;
    int         bad = 0;
    logic [31:0] model_cnt;

    logic [5:0] rfn  [4] = '{6'b100001, 6'b100011, 6'b100101, 6'b101010};
    logic [5:0] vops [5] = '{6'b001101, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    logic [5:0] bops [4] = '{6'b111111, 6'b000001, 6'b001000, 6'b100000};

    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(32)) if32 ();
    mc_ctrl_if #(.CNT_W(4))  if4 ();

    assign if32.op = op_r;  assign if32.funct = funct_r;  assign if32.zero = zero_r;
    assign if4.op  = op_r;  assign if4.funct  = funct_r;  assign if4.zero  = zero_r;

    mc_ctrl #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(if32));
    mc_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(if4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b100101 || fn == 6'b101010) ? C_R : C_BAD;
            6'b001101: return C_ORI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            default:   return C_BAD;
        endcase
    endfunction

    function automatic int path_len(input int cls);
        case (cls)
            C_LW:         return 5;
            C_R, C_ORI, C_SW: return 4;
            C_BEQ, C_J:   return 3;
            default:      return 2;
        endcase
    endfunction

    function automatic logic [3:0] path_state(input int cls, input int step);
        logic [3:0] lw_path [5] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd8};
        logic [3:0] sw_path [4] = '{4'd0, 4'd1, 4'd5, 4'd7};
        if (step < 2) return 4'(step);
        case (cls)
            C_R:     return (step == 2) ? 4'd2 : 4'd4;
            C_ORI:   return (step == 2) ? 4'd3 : 4'd4;
            C_LW:    return lw_path[step];
            C_SW:    return sw_path[step];
            C_BEQ:   return 4'd9;
            default: return 4'd10;
        endcase
    endfunction

    // {PCWr,IRWr,RegWr,MemWr,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ExtOp,PCSrc,ALUop}
    function automatic logic [14:0] pk(input logic pcwr, irwr, regwr, memwr, regdst, memtoreg, srca,
                                       input logic [1:0] srcb, input logic extop,
                                       input logic [1:0] pcsrc, input logic [2:0] aluop);
        return {pcwr, irwr, regwr, memwr, regdst, memtoreg, srca, srcb, extop, pcsrc, aluop};
    endfunction

    function automatic logic [14:0] exp_ctrl(input int cls, input int step, input logic [5:0] fn, input logic z);
        logic [2:0] rop;
        rop = (fn == 6'b100011) ? 3'b101 : (fn == 6'b100101) ? 3'b010 : (fn == 6'b101010) ? 3'b111 : 3'b001;
        if (step == 0) return pk(1, 1, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b001);
        if (step == 1) return pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 1, 2'b00, 3'b001);
        case (cls)
            C_R:   return (step == 2) ? pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00, rop)
                                      : pk(0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 2'b00, 3'b001);
            C_ORI: return (step == 2) ? pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b010)
                                      : pk(0, 0, 1, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b001);
            C_LW, C_SW: begin
                if (step == 2) return pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 3'b001);
                if (cls == C_SW) return pk(0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 2'b00, 3'b001);
                if (step == 3) return pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b001);
                return pk(0, 0, 1, 0, 0, 1, 0, 2'b00, 1, 2'b00, 3'b001);
            end
            C_BEQ: return pk(z, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b01, 3'b101);
            default: return pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b001);
        endcase
    endfunction

    // zsel: 0/1 forces the zero flag, 2 randomizes it; rst_at >= 0 asserts reset in that step instead.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zsel, input int rst_at);
        int cls;
        logic [14:0] obs;
        cls = classify(op, fn);
        for (int step = 0; step < path_len(cls); step++) begin
            if (step == 0) begin
                op_r    = op;
                funct_r = fn;
            end
            zero_r = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            if (step == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_state_hold", 32'(if32.state), 32'(path_state(cls, step)));
                chk("rst_wr_forced", 32'({if32.PCWr, if32.IRWr, if32.RegWr, if32.MemWr}), 32'd0);
                @(posedge clk); #1;
                chk("rst_state", 32'(if32.state), 32'd0);
                chk("rst_cnt", if32.instr_cnt, 32'd0);
                chk("rst_cnt4", 32'(if4.instr_cnt), 32'd0);
                rst       = 1'b0;
                model_cnt = 0;
                return;
            end
            #1;
            obs = {if32.PCWr, if32.IRWr, if32.RegWr, if32.MemWr, if32.RegDst, if32.MemtoReg, if32.ALUSrcA,
                   if32.ALUSrcB, if32.ExtOp, if32.PCSrc, if32.ALUop};
            chk($sformatf("state op=%b fn=%b step%0d", op, fn, step), 32'(if32.state), 32'(path_state(cls, step)));
            chk($sformatf("ctrl op=%b fn=%b step%0d", op, fn, step), 32'(obs),
                32'(exp_ctrl(cls, step, fn, zero_r)));
            chk("cnt", if32.instr_cnt, model_cnt);
            chk("cnt4", 32'(if4.instr_cnt), 32'(model_cnt[3:0]));
            @(posedge clk); #1;
        end
        if (cls != C_BAD) model_cnt = model_cnt + 1;
    endtask

    task automatic pick(input bit allow_bad, output logic [5:0] op, output logic [5:0] fn);
        int r;
        r  = allow_bad ? $urandom_range(0, 9) : $urandom_range(0, 8);
        fn = 6'($urandom);
        if (r < 4) begin
            op = 6'b000000;
            fn = rfn[$urandom_range(0, 3)];
        end else if (r < 9) begin
            op = vops[r - 4];
        end else if ($urandom_range(0, 1) == 1) begin
            op = bops[$urandom_range(0, 3)];
        end else begin
            op = 6'b000000;
            fn = 6'b000000;
        end
    endtask

    initial begin
        logic [5:0] rop, rfnv;
        rst       = 1'b1;
        op_r      = 6'b000000;
        funct_r   = 6'b000000;
        zero_r    = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("reset_state", 32'(if32.state), 32'd0);
            chk("reset_cnt", if32.instr_cnt, 32'd0);
            chk("reset_wr", 32'({if32.PCWr, if32.IRWr, if32.RegWr, if32.MemWr}), 32'd0);
        end
        rst = 1'b0;

        run_instr(6'b000000, 6'b100001, 2, -1);
        chk("addu_retired", if32.instr_cnt, 32'd1);
        run_instr(6'b100011, 6'b000000, 2, -1);
        run_instr(6'b101011, 6'b000000, 2, -1);
        run_instr(6'b000100, 6'b000000, 1, -1);
        run_instr(6'b000100, 6'b000000, 0, -1);
        run_instr(6'b001101, 6'b000000, 2, -1);
        run_instr(6'b000000, 6'b101010, 2, -1);
        run_instr(6'b000000, 6'b100011, 2, -1);
        run_instr(6'b000000, 6'b100101, 2, -1);
        run_instr(6'b000010, 6'b000000, 2, -1);
        run_instr(6'b111111, 6'b000000, 2, -1);
        run_instr(6'b000000, 6'b000000, 2, -1);
        chk("bad_not_counted", if32.instr_cnt, 32'd10);

        run_instr(6'b101011, 6'b000000, 2, 3);
        run_instr(6'b100011, 6'b000000, 2, 3);
        run_instr(6'b100011, 6'b000000, 2, 4);
        run_instr(6'b000100, 6'b000000, 1, 2);

        for (int i = 0; i < 16; i++) begin
            pick(1'b0, rop, rfnv);
            run_instr(rop, rfnv, 2, -1);
        end
        chk("wrap_cnt4", 32'(if4.instr_cnt), 32'd0);
        chk("wrap_cnt32", if32.instr_cnt, 32'd16);

        for (int i = 0; i < 60; i++) begin
            pick(1'b1, rop, rfnv);
            run_instr(rop, rfnv, 2, -1);
        end
        chk("final_cnt", if32.instr_cnt, model_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
